dp_exec_ctrl: RTL

//   Multi-cycle sequencer for ARM data-processing instructions. Accepts one 32-bit

---
 rtl/dp_exec_ctrl_if.sv | 33 +++
 rtl/dp_exec_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dp_exec_ctrl_if.sv
// Fetch-side and datapath-side signal bundle for the data-processing sequencer.
// master: the fetch stage / CPSR side that supplies the word and the flags.
// slave : the sequencer itself.
interface dp_exec_ctrl_if;
    logic        ir_valid;
    logic [31:0] ir;
    logic        ir_ready;
    logic [3:0]  nzcv_q;
    logic        busy;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [3:0]  rf_rs_addr;
    logic [3:0]  rf_wa_addr;
    logic        imm_sel;
    logic        shift_reg_sel;
    logic [3:0]  alu_op;
    logic        rf_we;
    logic        cpsr_we;
    logic        done;
    logic        undef;

    modport master (
        output ir_valid, ir, nzcv_q,
        input  ir_ready, busy, rf_ra_addr, rf_rb_addr, rf_rs_addr, rf_wa_addr,
               imm_sel, shift_reg_sel, alu_op, rf_we, cpsr_we, done, undef
    );

    modport slave (
        input  ir_valid, ir, nzcv_q,
        output ir_ready, busy, rf_ra_addr, rf_rb_addr, rf_rs_addr, rf_wa_addr,
               imm_sel, shift_reg_sel, alu_op, rf_we, cpsr_we, done, undef
    );
endinterface

// File: rtl/dp_exec_ctrl.sv
// Multi-cycle sequencer for ARM data-processing instructions.
// Latches one instruction word, checks its condition against the CPSR flags,
// then steps READ -> [READS] -> EXEC -> WB, driving register-file addresses,
// ALU opcode, shifter selects and the write strobes on a fixed schedule.
// Optional performance counters are built when DP_CTRL_PERF_EN is defined;
// otherwise exec_cnt and skip_cnt are tied to zero.
module dp_exec_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dp_exec_ctrl_if.slave    bus,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    // RETIRE is the single done cycle for undefined or condition-failed words.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_COND   = 3'd1,
        S_RETIRE = 3'd2,
        S_READ   = 3'd3,
        S_READS  = 3'd4,
        S_EXEC   = 3'd5,
        S_WB     = 3'd6
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] ir_q,      ir_d;
    logic        done_q,    done_d;
    logic        undef_q,   undef_d;
    logic        rf_we_q,   rf_we_d;
    logic        cpsr_we_q, cpsr_we_d;
    logic [3:0]  alu_op_q,  alu_op_d;

    // Fields of the latched word.
    logic [3:0] cond_f;
    logic [3:0] opcode_f;
    logic       s_bit;
    logic       is_test_op;
    logic       shift_by_reg;
    logic       undef_enc;
    logic       cond_pass;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign cond_f       = ir_q[31:28];
    assign opcode_f     = ir_q[24:21];
    assign s_bit        = ir_q[20];
    assign is_test_op   = (opcode_f[3:2] == 2'b10);
    assign shift_by_reg = !ir_q[25] && ir_q[4];

    assign flag_n = bus.nzcv_q[3];
    assign flag_z = bus.nzcv_q[2];
    assign flag_c = bus.nzcv_q[1];
    assign flag_v = bus.nzcv_q[0];

    // Encodings this controller does not execute: NV space, non-data-processing
    // classes, the multiply/extra-load space, flagless compares, and S with Rd=PC.
    assign undef_enc = (cond_f == 4'hF)
                    || (ir_q[27:26] != 2'b00)
                    || (!ir_q[25] && ir_q[7] && ir_q[4])
                    || (is_test_op && !s_bit)
                    || (s_bit && (ir_q[15:12] == 4'hF));

    // ARM condition-code evaluation against the live flags (used only in COND).
    always_comb begin
        cond_pass = 1'b0;
        case (cond_f)
            4'h0: cond_pass = flag_z;
            4'h1: cond_pass = !flag_z;
            4'h2: cond_pass = flag_c;
            4'h3: cond_pass = !flag_c;
            4'h4: cond_pass = flag_n;
            4'h5: cond_pass = !flag_n;
            4'h6: cond_pass = flag_v;
            4'h7: cond_pass = !flag_v;
            4'h8: cond_pass = flag_c && !flag_z;
            4'h9: cond_pass = !flag_c || flag_z;
            4'hA: cond_pass = (flag_n == flag_v);
            4'hB: cond_pass = (flag_n != flag_v);
            4'hC: cond_pass = !flag_z && (flag_n == flag_v);
            4'hD: cond_pass = flag_z || (flag_n != flag_v);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Next-state and next-output logic; every strobe is computed one cycle ahead
    // so that it leaves the block straight from a flop.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        done_d    = 1'b0;
        undef_d   = 1'b0;
        rf_we_d   = 1'b0;
        cpsr_we_d = 1'b0;
        alu_op_d  = 4'h0;
        case (state_q)
            S_IDLE: begin
                if (bus.ir_valid) begin
                    ir_d    = bus.ir;
                    state_d = S_COND;
                end
            end
            S_COND: begin
                if (undef_enc) begin
                    state_d = S_RETIRE;
                    done_d  = 1'b1;
                    undef_d = 1'b1;
                end else if (!cond_pass) begin
                    state_d = S_RETIRE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_READ;
                end
            end
            S_RETIRE: begin
                state_d = S_IDLE;
            end
            S_READ: begin
                if (shift_by_reg) begin
                    state_d = S_READS;
                end else begin
                    state_d  = S_EXEC;
                    alu_op_d = opcode_f;
                end
            end
            S_READS: begin
                state_d  = S_EXEC;
                alu_op_d = opcode_f;
            end
            S_EXEC: begin
                state_d   = S_WB;
                alu_op_d  = opcode_f;
                done_d    = 1'b1;
                rf_we_d   = !is_test_op;
                cpsr_we_d = s_bit;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, instruction latch and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ir_q      <= 32'h0;
            done_q    <= 1'b0;
            undef_q   <= 1'b0;
            rf_we_q   <= 1'b0;
            cpsr_we_q <= 1'b0;
            alu_op_q  <= 4'h0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            done_q    <= done_d;
            undef_q   <= undef_d;
            rf_we_q   <= rf_we_d;
            cpsr_we_q <= cpsr_we_d;
            alu_op_q  <= alu_op_d;
        end
    end

    assign bus.ir_ready      = (state_q == S_IDLE);
    assign bus.busy          = (state_q != S_IDLE);
    assign bus.rf_ra_addr    = ir_q[19:16];
    assign bus.rf_rb_addr    = ir_q[3:0];
    assign bus.rf_rs_addr    = ir_q[11:8];
    assign bus.rf_wa_addr    = ir_q[15:12];
    assign bus.imm_sel       = ir_q[25];
    assign bus.shift_reg_sel = shift_by_reg;
    assign bus.alu_op        = alu_op_q;
    assign bus.rf_we         = rf_we_q;
    assign bus.cpsr_we       = cpsr_we_q;
    assign bus.done          = done_q;
    assign bus.undef         = undef_q;

`ifdef DP_CTRL_PERF_EN
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

    // Counters advance on the same edge that raises the matching done pulse.
    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (state_q == S_EXEC) begin
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
        if ((state_q == S_COND) && !undef_enc && !cond_pass) begin
            skip_cnt_d = skip_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers; wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign exec_cnt = exec_cnt_q;
    assign skip_cnt = skip_cnt_q;
`else
    assign exec_cnt = '0;
    assign skip_cnt = '0;
`endif

endmodule
